id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised successor decode stage for the riscv_cpu pipeline. It sits between IF and EX and contains the integer register file and the full RV32I/E decoder, which produces immediates for every format. It adds valid/ready handshaking on both sides, load-use hazard stalling, flush, and precomputed branch/jump targets. All outputs are registered; the stage is one cycle deep.

Parameters:
XLEN, 32, data path and register width (32 only is supported; sized for future RV64 reuse)
NREGS, 32, architectural registers; 32 for RV32I, 16 for RV32E
ALU_OP_W, 4, width of the alu_op_o encoding

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
valid_i  in  1  IF presents an instruction
ready_o  out  1  stage accepts the instruction this cycle
instr_i  in  32  instruction word
pc_i  in  32  instruction PC
flush_i  in  1  kill the instruction in the stage and the incoming instruction (branch taken in EX)
ex_valid_i  in  1  EX holds a valid instruction
ex_is_load_i  in  1  EX instruction is a load
ex_rd_i  in  5  EX destination register
wb_we_i  in  1  writeback enable
wb_waddr_i  in  5  writeback register
wb_wdata_i  in  XLEN  writeback data
valid_o  out  1  decoded instruction valid
ready_i  in  1  EX accepts
op_a_o  out  XLEN  ALU operand A
op_b_o  out  XLEN  ALU operand B
rs2_data_o  out  XLEN  store data
imm_o  out  XLEN  sign-extended immediate
rd_addr_o  out  5  destination register
rd_we_o  out  1  writes rd
alu_op_o  out  ALU_OP_W  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
is_load_o / is_store_o / branch_o / jump_o  out  1 each  class flags
funct3_o  out  3  funct3 of the instruction, passed through for LSU/branch compare
target_o  out  32  pc+imm (JAL, branch) or 0 for others; JALR target computed in EX
pc_o  out  32  PC of the decoded instruction
illegal_o  out  1  unsupported opcode, or register index >= NREGS

Behaviour:
- Reset (rst_i high, async): all outputs 0, valid_o=0, all registers in the register file = 0.
- Register file: x0 reads 0. Write occurs at clock edge when wb_we_i and wb_waddr_i!=0 and wb_waddr_i<NREGS; other writes are ignored.
- hazard = valid_i & ex_valid_i & ex_is_load_i & ex_rd_i!=0 & (rs1 used & rs1==ex_rd_i | rs2 used & rs2==ex_rd_i).
- advance = ~valid_o | ready_i.
- ready_o = flush_i | (advance & ~hazard).
- Stage register update, in priority order:
  - flush_i: valid_o<=0; the input is dropped.
  - advance: all payload outputs load and valid_o <= valid_i & ~hazard, so a hazard inserts exactly one bubble per load.
  - otherwise: hold; outputs stay bit-stable while valid_o & ~ready_i.
- Immediates: I, S, B, U, J formats, all sign-extended to XLEN; B and J have bit 0 = 0; U is imm[31:12]<<12.
- Operand select:
  - op_a = pc for AUIPC/JAL/JALR, 0 for LUI, else rs1.
  - op_b = 4 for JAL/JALR; imm for I/S/U-type; rs2 for R/B-type.
- ALU op:
  - ALU ops decoded from funct3/funct7[5]; SUB and SRA use funct7[5].
  - Branches use SUB, loads/stores use ADD, LUI uses PASS_B.
- rd_we_o = 1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR; forced to 0 when rd=0 or illegal.
- Illegal instruction: passed downstream valid with illegal_o=1, rd_we_o=0, is_store_o=0.
- flush_i and hazard together: flush wins, ready_o=1.
- Reset mid-stall: stage is empty after release; the instruction is refetched by IF.

Optional Feature:
WB_BYPASS_EN: when defined, a read whose address equals wb_waddr_i with wb_we_i high (address nonzero) returns wb_wdata_i in the same cycle. When undefined, the read returns the old register value and software must space a writeback and a dependent read by one instruction.

Test Plan:
- Reset, then ADDI x1,x0,-5 with valid_i=1, ready_i=1 -> next cycle valid_o=1, op_a=0, op_b=imm=0xFFFFFFFB, alu_op=0, rd=1, rd_we=1.
- ex_valid_i=1, ex_is_load_i=1, ex_rd_i=3, then ADD x4,x3,x2 -> ready_o=0 for one cycle, one bubble (valid_o=0); after ex_is_load_i drops, ADD is issued.
- ready_i=0 with valid_o=1 for 3 cycles -> ready_o=0, outputs unchanged; ready_i=1 -> next instruction loads.
- JAL x1,+2048 at pc=0x100 -> target_o=0x900, op_a=0x100, op_b=4, jump_o=1; flush_i next cycle -> valid_o=0.
- Writeback x5=0x1234, same cycle ADD x6,x5,x0 -> op_a=0x1234 with WB_BYPASS_EN, old value (0) without it.
- NREGS=16: ADD x17,x1,x2 -> illegal_o=1, rd_we_o=0; writeback to x20 is ignored.

Source files
------------

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF-side handshake, EX-side hazard/writeback inputs and the
// registered decode payload. "slave" is the stage view, "master" the environment.
interface id_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                valid_i;
    logic                ready_o;
    logic [31:0]         instr_i;
    logic [31:0]         pc_i;
    logic                flush_i;
    logic                ex_valid_i;
    logic                ex_is_load_i;
    logic [4:0]          ex_rd_i;
    logic                wb_we_i;
    logic [4:0]          wb_waddr_i;
    logic [XLEN-1:0]     wb_wdata_i;
    logic                valid_o;
    logic                ready_i;
    logic [XLEN-1:0]     op_a_o;
    logic [XLEN-1:0]     op_b_o;
    logic [XLEN-1:0]     rs2_data_o;
    logic [XLEN-1:0]     imm_o;
    logic [4:0]          rd_addr_o;
    logic                rd_we_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic                is_load_o;
    logic                is_store_o;
    logic                branch_o;
    logic                jump_o;
    logic [2:0]          funct3_o;
    logic [31:0]         target_o;
    logic [31:0]         pc_o;
    logic                illegal_o;

    modport master (
        output valid_i, instr_i, pc_i, flush_i, ex_valid_i, ex_is_load_i, ex_rd_i,
               wb_we_i, wb_waddr_i, wb_wdata_i, ready_i,
        input  ready_o, valid_o, op_a_o, op_b_o, rs2_data_o, imm_o, rd_addr_o, rd_we_o,
               alu_op_o, is_load_o, is_store_o, branch_o, jump_o, funct3_o, target_o,
               pc_o, illegal_o
    );

    modport slave (
        input  valid_i, instr_i, pc_i, flush_i, ex_valid_i, ex_is_load_i, ex_rd_i,
               wb_we_i, wb_waddr_i, wb_wdata_i, ready_i,
        output ready_o, valid_o, op_a_o, op_b_o, rs2_data_o, imm_o, rd_addr_o, rd_we_o,
               alu_op_o, is_load_o, is_store_o, branch_o, jump_o, funct3_o, target_o,
               pc_o, illegal_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I/E decode stage: register file, full decoder, load-use stall, flush and
// precomputed branch/JAL targets. One registered stage with valid/ready on both sides.
// Optional macro WB_BYPASS_EN: same-cycle writeback-to-read bypass in the register file.
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ALU_OP_W = 4
) (
    input logic     clk_i,
    input logic     rst_i,
    id_stage_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);

    typedef struct packed {
        logic [XLEN-1:0]     op_a;
        logic [XLEN-1:0]     op_b;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rd;
        logic                rd_we;
        logic [ALU_OP_W-1:0] alu_op;
        logic                is_load;
        logic                is_store;
        logic                branch;
        logic                jump;
        logic [2:0]          funct3;
        logic [31:0]         target;
        logic [31:0]         pc;
        logic                illegal;
    } payload_t;

    logic [XLEN-1:0] rf [NREGS];
    payload_t        d, q;
    logic            valid_q;

    logic [31:0] instr;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    logic rs1_used, rs2_used, rd_used, legal_op, hazard, advance;

    assign instr = bus.instr_i;
    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // Register read: x0 and out-of-range indices read zero; optional writeback bypass
    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != 5'd0 && int'(a) < NREGS) begin
            v = rf[a[AW-1:0]];
`ifdef WB_BYPASS_EN
            if (bus.wb_we_i && bus.wb_waddr_i == a) v = bus.wb_wdata_i;
`endif
        end
        return v;
    endfunction

    // Shared funct3/funct7[5] ALU decode; SUB exists only for register-register ops
    function automatic logic [ALU_OP_W-1:0] alu_dec(input logic [2:0] fn, input logic b30,
                                                    input logic is_reg);
        logic [ALU_OP_W-1:0] r;
        case (fn)
            3'd0:    r = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    r = ALU_OP_W'(2);
            3'd2:    r = ALU_OP_W'(3);
            3'd3:    r = ALU_OP_W'(4);
            3'd4:    r = ALU_OP_W'(5);
            3'd5:    r = b30 ? ALU_OP_W'(7) : ALU_OP_W'(6);
            3'd6:    r = ALU_OP_W'(8);
            default: r = ALU_OP_W'(9);
        endcase
        return r;
    endfunction

    // Register operand fetch
    always_comb begin
        rs1_val = read_reg(rs1);
        rs2_val = read_reg(rs2);
    end

    // Instruction decode into the next payload
    always_comb begin
        d        = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        legal_op = 1'b1;
        case (opc)
            OPC_LUI: begin
                d.op_b = imm_u; d.imm = imm_u; d.alu_op = ALU_PASS_B; rd_used = 1'b1;
            end
            OPC_AUIPC: begin
                d.op_a = bus.pc_i; d.op_b = imm_u; d.imm = imm_u; rd_used = 1'b1;
            end
            OPC_JAL: begin
                d.op_a = bus.pc_i; d.op_b = XLEN'(4); d.imm = imm_j; d.jump = 1'b1;
                d.target = bus.pc_i + imm_j[31:0]; rd_used = 1'b1;
            end
            OPC_JALR: begin
                d.op_a = bus.pc_i; d.op_b = XLEN'(4); d.imm = imm_i; d.jump = 1'b1;
                rs1_used = 1'b1; rd_used = 1'b1;
            end
            OPC_BRANCH: begin
                d.op_a = rs1_val; d.op_b = rs2_val; d.imm = imm_b; d.branch = 1'b1;
                d.alu_op = ALU_SUB; d.target = bus.pc_i + imm_b[31:0];
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                d.op_a = rs1_val; d.op_b = imm_i; d.imm = imm_i; d.is_load = 1'b1;
                rs1_used = 1'b1; rd_used = 1'b1;
            end
            OPC_STORE: begin
                d.op_a = rs1_val; d.op_b = imm_s; d.imm = imm_s; d.is_store = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_OPIMM: begin
                d.op_a = rs1_val; d.op_b = imm_i; d.imm = imm_i;
                d.alu_op = alu_dec(f3, instr[30], 1'b0); rs1_used = 1'b1; rd_used = 1'b1;
            end
            OPC_OP: begin
                d.op_a = rs1_val; d.op_b = rs2_val;
                d.alu_op = alu_dec(f3, instr[30], 1'b1);
                rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1;
            end
            default: legal_op = 1'b0;
        endcase
        d.rs2_data = rs2_used ? rs2_val : '0;
        d.illegal  = ~legal_op | (rs1_used & (int'(rs1) >= NREGS))
                   | (rs2_used & (int'(rs2) >= NREGS)) | (rd_used & (int'(rd) >= NREGS));
        // Illegal instructions travel downstream as inert markers
        if (d.illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        d.rd_we  = rd_used & (rd != 5'd0) & ~d.illegal;
        d.rd     = rd;
        d.funct3 = f3;
        d.pc     = bus.pc_i;
    end

    assign hazard  = bus.valid_i & bus.ex_valid_i & bus.ex_is_load_i & (bus.ex_rd_i != 5'd0)
                   & ((rs1_used & (rs1 == bus.ex_rd_i)) | (rs2_used & (rs2 == bus.ex_rd_i)));
    assign advance = ~valid_q | bus.ready_i;
    assign bus.ready_o = bus.flush_i | (advance & ~hazard);

    // Register file write port; x0 and indices beyond NREGS are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.wb_we_i && bus.wb_waddr_i != 5'd0 && int'(bus.wb_waddr_i) < NREGS) begin
            rf[bus.wb_waddr_i[AW-1:0]] <= bus.wb_wdata_i;
        end
    end

    // Stage register: flush beats advance; a hazard loads a bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= bus.valid_i & ~hazard;
            q       <= d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.op_a_o     = q.op_a;
    assign bus.op_b_o     = q.op_b;
    assign bus.rs2_data_o = q.rs2_data;
    assign bus.imm_o      = q.imm;
    assign bus.rd_addr_o  = q.rd;
    assign bus.rd_we_o    = q.rd_we;
    assign bus.alu_op_o   = q.alu_op;
    assign bus.is_load_o  = q.is_load;
    assign bus.is_store_o = q.is_store;
    assign bus.branch_o   = q.branch;
    assign bus.jump_o     = q.jump;
    assign bus.funct3_o   = q.funct3;
    assign bus.target_o   = q.target;
    assign bus.pc_o       = q.pc;
    assign bus.illegal_o  = q.illegal;
endmodule
